lsu_ctrl: RTL and testbench



---
 rtl/lsu_ctrl_pkg.sv | 22 ++
 rtl/lsu_ctrl_if.sv | 23 ++
 rtl/lsu_align.sv | 72 +++++++
 rtl/lsu_ctrl.sv | 105 ++++++++++
 tb/tb_lsu_ctrl.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_ctrl_pkg.sv
// Shared memory-operation decode codes and the LSU sequencer state encoding.
package lsu_ctrl_pkg;

   localparam logic [3:0] MT_X  = 4'd0;
   localparam logic [3:0] MT_B  = 4'd1;
   localparam logic [3:0] MT_H  = 4'd2;
   localparam logic [3:0] MT_W  = 4'd3;
   localparam logic [3:0] MT_BU = 4'd4;
   localparam logic [3:0] MT_HU = 4'd5;

   localparam logic [1:0] M_X = 2'd0;
   localparam logic [1:0] M_R = 2'd1;
   localparam logic [1:0] M_W = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_RESP
   } lsu_state_e;

endpackage

// File: rtl/lsu_ctrl_if.sv
// Data-memory port bundle: request/grant/response bus between the LSU and memory.
interface lsu_ctrl_if;

   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_gnt, mem_rvalid, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_gnt, mem_rvalid, mem_rdata
   );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store replication, legality check,
// and load byte/half extraction with sign or zero extension.
module lsu_align
   import lsu_ctrl_pkg::*;
(
   input  logic [1:0]  req_write,
   input  logic [3:0]  req_type,
   input  logic [1:0]  req_off,
   input  logic [31:0] req_wdata,
   output logic [3:0]  be,
   output logic [31:0] lane_wdata,
   output logic        illegal,
   input  logic [3:0]  ld_type,
   input  logic [1:0]  ld_off,
   input  logic [31:0] rdata,
   output logic [31:0] ld_data
);

   logic               store;
   logic [31:0]        rshift;
   logic signed [7:0]  ld_byte;
   logic signed [15:0] ld_half;
   logic signed [31:0] sext_byte;
   logic signed [31:0] sext_half;

   assign store = (req_write == M_W);

   always_comb begin
      be         = 4'b0000;
      lane_wdata = '0;
      illegal    = 1'b0;
      case (req_type)
         MT_B, MT_BU: begin
            be         = 4'b0001 << req_off;
            lane_wdata = {4{req_wdata[7:0]}};
         end
         MT_H, MT_HU: begin
            be         = 4'b0011 << req_off;
            lane_wdata = {2{req_wdata[15:0]}};
            illegal    = req_off[0];
         end
         MT_W: begin
            be         = 4'b1111;
            lane_wdata = req_wdata;
            illegal    = (req_off != 2'b00);
         end
         MT_X:    illegal = 1'b1;
         default: illegal = 1'b1;
      endcase
      // Unsigned widths only make sense for loads; unknown write codes are rejected too.
      if (store && (req_type == MT_BU || req_type == MT_HU)) illegal = 1'b1;
      if (!store && req_write != M_R) illegal = 1'b1;
      if (!store) lane_wdata = '0;
   end

   assign rshift    = rdata >> {ld_off, 3'b000};
   assign ld_byte   = rshift[7:0];
   assign ld_half   = rshift[15:0];
   assign sext_byte = ld_byte;
   assign sext_half = ld_half;

   always_comb begin
      case (ld_type)
         MT_B:    ld_data = sext_byte;
         MT_H:    ld_data = sext_half;
         MT_BU:   ld_data = {24'b0, rshift[7:0]};
         MT_HU:   ld_data = {16'b0, rshift[15:0]};
         default: ld_data = rshift;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: accepts one memory op, runs a req/gnt/rvalid bus
// transaction, and returns extended load data or an access error.
module lsu_ctrl
   import lsu_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_write,
   input  logic [3:0]  req_type,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall,
   lsu_ctrl_if.master  bus,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   lsu_state_e  state;
   logic [3:0]  type_p1;
   logic [1:0]  off_p1;
   logic [3:0]  be;
   logic [31:0] lane_wdata;
   logic        illegal;
   logic [31:0] ld_data;

   assign req_ready = (state == S_IDLE);
   assign stall     = (state != S_IDLE);

   lsu_align u_align (
      .req_write  (req_write),
      .req_type   (req_type),
      .req_off    (req_addr[1:0]),
      .req_wdata  (req_wdata),
      .be         (be),
      .lane_wdata (lane_wdata),
      .illegal    (illegal),
      .ld_type    (type_p1),
      .ld_off     (off_p1),
      .rdata      (bus.mem_rdata),
      .ld_data    (ld_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         type_p1       <= MT_X;
         off_p1        <= 2'b00;
         bus.mem_req   <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_be    <= 4'b0000;
         bus.mem_wdata <= '0;
         resp_valid    <= 1'b0;
         resp_rdata    <= '0;
         resp_err      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid && req_write != M_X) begin
                  if (illegal) begin
                     state      <= S_RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= '0;
                  end else begin
                     state         <= S_REQ;
                     type_p1       <= req_type;
                     off_p1        <= req_addr[1:0];
                     bus.mem_req   <= 1'b1;
                     bus.mem_we    <= (req_write == M_W);
                     bus.mem_addr  <= {req_addr[31:2], 2'b00};
                     bus.mem_be    <= be;
                     bus.mem_wdata <= lane_wdata;
                  end
               end
            end
            // Bus fields stay frozen while the request waits for a grant.
            S_REQ: begin
               if (bus.mem_gnt) begin
                  state       <= S_WAIT;
                  bus.mem_req <= 1'b0;
               end
            end
            S_WAIT: begin
               if (bus.mem_rvalid) begin
                  state      <= S_RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b0;
                  resp_rdata <= bus.mem_we ? 32'h0 : ld_data;
               end
            end
            S_RESP: begin
               state      <= S_IDLE;
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized and directed bench for lsu_ctrl against a spec-level reference model.
module tb_lsu_ctrl;
   import lsu_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_write;
   logic [3:0]  req_type;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        stall;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   int          total  = 0;
   int          passed = 0;

   lsu_ctrl_if bus ();

   lsu_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_type   (req_type),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .stall      (stall),
      .bus        (bus),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err)
   );

   always #5 clk = ~clk;

   // Reference: derive bus fields and result from access size and offset arithmetic.
   task automatic model(input logic [1:0] wr, input logic [3:0] ty, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd, output bit err,
                        output logic [3:0] be, output logic [31:0] mw, output logic [31:0] rr);
      int size;
      int off;
      bit uns;
      logic [31:0] v;
      logic [31:0] mask;
      off  = int'(addr[1:0]);
      size = 0;
      uns  = 1'b0;
      case (ty)
         4'd1: size = 1;
         4'd2: size = 2;
         4'd3: size = 4;
         4'd4: begin size = 1; uns = 1'b1; end
         4'd5: begin size = 2; uns = 1'b1; end
         default: size = 0;
      endcase
      err = (size == 0) || (wr != 2'd1 && wr != 2'd2) || (wr == 2'd2 && uns) ||
            (size != 0 && (off % size) != 0);
      be  = 4'(((1 << size) - 1) << off);
      mw  = 32'h0;
      if (wr == 2'd2) begin
         if (size == 1) mw = (wd & 32'hFF) * 32'h0101_0101;
         else if (size == 2) mw = (wd & 32'hFFFF) * 32'h0001_0001;
         else mw = wd;
      end
      rr = 32'h0;
      if (wr == 2'd1 && size != 0) begin
         v = rd >> (8 * off);
         if (size == 4) rr = v;
         else begin
            mask = (size == 1) ? 32'hFF : 32'hFFFF;
            rr   = v & mask;
            if (!uns && (rr & ((mask + 32'h1) >> 1)) != 32'h0) rr = rr | ~mask;
         end
      end
   endtask

   task automatic do_op(input string name, input logic [1:0] wr, input logic [3:0] ty,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                        input int gnt_dly, input int rv_dly, input bit gnt_rv_same,
                        input bit exp_err, input logic [3:0] exp_be, input logic [31:0] exp_mw,
                        input logic [31:0] exp_rr);
      logic [31:0] exp_addr;
      logic        exp_we;
      exp_addr = {addr[31:2], 2'b00};
      exp_we   = (wr == M_W);
      @(negedge clk);
      total++;
      if (req_ready !== 1'b1) $display("FAIL %s idle_ready: got %b want 1", name, req_ready);
      else passed++;
      req_valid = 1'b1; req_write = wr; req_type = ty; req_addr = addr; req_wdata = wd;
      @(negedge clk);
      req_valid = 1'b0; req_wdata = $urandom;
      if (exp_err) begin
         total++;
         if ({resp_valid, resp_err, bus.mem_req, resp_rdata} !== {1'b1, 1'b1, 1'b0, 32'h0})
            $display("FAIL %s err_resp: got v=%b e=%b req=%b d=%h want v=1 e=1 req=0 d=0",
                     name, resp_valid, resp_err, bus.mem_req, resp_rdata);
         else passed++;
         @(negedge clk);
         total++;
         if ({resp_valid, req_ready, bus.mem_req, stall} !== 4'b0100)
            $display("FAIL %s err_done: got v=%b rdy=%b req=%b stall=%b want 0,1,0,0",
                     name, resp_valid, req_ready, bus.mem_req, stall);
         else passed++;
      end else begin
         total++;
         if ({bus.mem_req, bus.mem_we, stall, req_ready} !== {1'b1, exp_we, 1'b1, 1'b0})
            $display("FAIL %s req_ctrl: got req=%b we=%b stall=%b rdy=%b want 1,%b,1,0",
                     name, bus.mem_req, bus.mem_we, stall, req_ready, exp_we);
         else passed++;
         total++;
         if (bus.mem_addr !== exp_addr) $display("FAIL %s mem_addr: got %h want %h", name, bus.mem_addr, exp_addr);
         else passed++;
         total++;
         if (bus.mem_be !== exp_be) $display("FAIL %s mem_be: got %b want %b", name, bus.mem_be, exp_be);
         else passed++;
         total++;
         if (bus.mem_wdata !== exp_mw) $display("FAIL %s mem_wdata: got %h want %h", name, bus.mem_wdata, exp_mw);
         else passed++;
         for (int i = 0; i < gnt_dly; i++) begin
            @(negedge clk);
            total++;
            if ({bus.mem_req, stall, req_ready, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata} !==
                {1'b1, 1'b1, 1'b0, exp_we, exp_addr, exp_be, exp_mw})
               $display("FAIL %s hold_%0d: got req=%b stall=%b rdy=%b a=%h be=%b d=%h want 1,1,0 a=%h be=%b d=%h",
                        name, i, bus.mem_req, stall, req_ready, bus.mem_addr, bus.mem_be, bus.mem_wdata,
                        exp_addr, exp_be, exp_mw);
            else passed++;
         end
         bus.mem_gnt = 1'b1;
         if (gnt_rv_same) begin bus.mem_rvalid = 1'b1; bus.mem_rdata = ~rd; end
         @(negedge clk);
         bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
         total++;
         if ({bus.mem_req, resp_valid, stall} !== 3'b001)
            $display("FAIL %s granted: got req=%b v=%b stall=%b want 0,0,1", name, bus.mem_req, resp_valid, stall);
         else passed++;
         for (int i = 0; i < rv_dly; i++) begin
            @(negedge clk);
            total++;
            if ({resp_valid, stall, bus.mem_req} !== 3'b010)
               $display("FAIL %s wait_%0d: got v=%b stall=%b req=%b want 0,1,0", name, i, resp_valid, stall, bus.mem_req);
            else passed++;
         end
         bus.mem_rvalid = 1'b1; bus.mem_rdata = rd;
         @(negedge clk);
         bus.mem_rvalid = 1'b0; bus.mem_rdata = $urandom;
         total++;
         if ({resp_valid, resp_err, stall} !== 3'b101)
            $display("FAIL %s resp_ctrl: got v=%b e=%b stall=%b want 1,0,1", name, resp_valid, resp_err, stall);
         else passed++;
         total++;
         if (resp_rdata !== exp_rr) $display("FAIL %s resp_rdata: got %h want %h", name, resp_rdata, exp_rr);
         else passed++;
         @(negedge clk);
         total++;
         if ({resp_valid, req_ready, stall} !== 3'b010)
            $display("FAIL %s done: got v=%b rdy=%b stall=%b want 0,1,0", name, resp_valid, req_ready, stall);
         else passed++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_valid = 1'b0; req_write = M_X; req_type = MT_X;
      req_addr = '0; req_wdata = '0;
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
      repeat (3) @(negedge clk);
      total++;
      if ({req_ready, stall, resp_valid, resp_err} !== 4'b1000)
         $display("FAIL reset_ctrl: got rdy=%b stall=%b v=%b e=%b want 1,0,0,0", req_ready, stall, resp_valid, resp_err);
      else passed++;
      total++;
      if ({bus.mem_req, bus.mem_we, bus.mem_be} !== 6'b0)
         $display("FAIL reset_bus: got req=%b we=%b be=%b want 0,0,0000", bus.mem_req, bus.mem_we, bus.mem_be);
      else passed++;
      total++;
      if ({bus.mem_addr, bus.mem_wdata, resp_rdata} !== 96'h0)
         $display("FAIL reset_data: got a=%h d=%h r=%h want 0", bus.mem_addr, bus.mem_wdata, resp_rdata);
      else passed++;
      rst_n = 1'b1;
   endtask

   task automatic test_directed();
      do_op("lb_1003",  M_R, MT_B,  32'h0000_1003, 32'h0, 32'h80AA_BBCC, 0, 0, 0, 0, 4'b1000, 32'h0, 32'hFFFF_FF80);
      do_op("lhu_2002", M_R, MT_HU, 32'h0000_2002, 32'h0, 32'h8001_1234, 0, 0, 0, 0, 4'b1100, 32'h0, 32'h0000_8001);
      do_op("sb_0001",  M_W, MT_B,  32'h0000_0001, 32'h1234_56A5, 32'h0, 0, 1, 0, 0, 4'b0010, 32'hA5A5_A5A5, 32'h0);
      do_op("lh_0000",  M_R, MT_H,  32'h0000_0000, 32'h0, 32'h0000_8000, 1, 0, 0, 0, 4'b0011, 32'h0, 32'hFFFF_8000);
      do_op("sh_0002",  M_W, MT_H,  32'h0000_0002, 32'hABCD_1234, 32'h0, 0, 0, 0, 0, 4'b1100, 32'h1234_1234, 32'h0);
      do_op("lbu_0001", M_R, MT_BU, 32'h0000_0001, 32'h0, 32'h0000_F000, 0, 2, 0, 0, 4'b0010, 32'h0, 32'h0000_00F0);
      do_op("lw_0010",  M_R, MT_W,  32'h0000_0010, 32'h0, 32'hCAFE_F00D, 0, 0, 0, 0, 4'b1111, 32'h0, 32'hCAFE_F00D);
   endtask

   task automatic test_illegal();
      do_op("lw_0006",  M_R, MT_W,  32'h0000_0006, 32'h0, 32'h0, 0, 0, 0, 1, 4'b0, 32'h0, 32'h0);
      do_op("sbu",      M_W, MT_BU, 32'h0000_0000, 32'h55, 32'h0, 0, 0, 0, 1, 4'b0, 32'h0, 32'h0);
      do_op("mt_x",     M_R, MT_X,  32'h0000_0000, 32'h0, 32'h0, 0, 0, 0, 1, 4'b0, 32'h0, 32'h0);
      do_op("mt_7",     M_R, 4'd7,  32'h0000_0000, 32'h0, 32'h0, 0, 0, 0, 1, 4'b0, 32'h0, 32'h0);
      do_op("sh_0003",  M_W, MT_H,  32'h0000_0003, 32'h0, 32'h0, 0, 0, 0, 1, 4'b0, 32'h0, 32'h0);
   endtask

   task automatic test_gnt_stall();
      do_op("sw_gnt5", M_W, MT_W, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 5, 0, 0, 0, 4'b1111, 32'hDEAD_BEEF, 32'h0);
      do_op("lb_gnt_rv", M_R, MT_B, 32'h0000_0202, 32'h0, 32'h0011_7F00, 2, 1, 1, 0, 4'b0100, 32'h0, 32'h0000_0011);
   endtask

   task automatic test_not_an_op();
      @(negedge clk);
      req_valid = 1'b1; req_write = M_X; req_type = MT_W; req_addr = 32'h40;
      bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0; bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
      total++;
      if ({req_ready, stall, bus.mem_req, resp_valid} !== 4'b1000)
         $display("FAIL m_x_idle: got rdy=%b stall=%b req=%b v=%b want 1,0,0,0", req_ready, stall, bus.mem_req, resp_valid);
      else passed++;
      @(negedge clk);
      total++;
      if ({req_ready, resp_valid} !== 2'b10)
         $display("FAIL m_x_after: got rdy=%b v=%b want 1,0", req_ready, resp_valid);
      else passed++;
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      req_valid = 1'b1; req_write = M_W; req_type = MT_W; req_addr = 32'h44; req_wdata = 32'h1357_9BDF;
      @(negedge clk);
      req_valid = 1'b0; bus.mem_gnt = 1'b1;
      @(negedge clk);
      bus.mem_gnt = 1'b0;
      total++;
      if (stall !== 1'b1) $display("FAIL rst_mid_wait: got stall=%b want 1", stall);
      else passed++;
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({req_ready, stall, bus.mem_req, bus.mem_we, bus.mem_be, resp_valid, resp_err} !== 10'b10_0000_0000)
         $display("FAIL rst_mid_ctrl: got rdy=%b stall=%b req=%b we=%b be=%b v=%b e=%b want 1,0,0,0,0000,0,0",
                  req_ready, stall, bus.mem_req, bus.mem_we, bus.mem_be, resp_valid, resp_err);
      else passed++;
      total++;
      if ({bus.mem_addr, bus.mem_wdata} !== 64'h0)
         $display("FAIL rst_mid_data: got a=%h d=%h want 0", bus.mem_addr, bus.mem_wdata);
      else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      bus.mem_rvalid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         total++;
         if ({resp_valid, req_ready, stall} !== 3'b010)
            $display("FAIL rst_mid_late_%0d: got v=%b rdy=%b stall=%b want 0,1,0", i, resp_valid, req_ready, stall);
         else passed++;
         @(negedge clk);
      end
   endtask

   task automatic test_random();
      logic [1:0]  wr;
      logic [3:0]  ty;
      logic [31:0] addr, wd, rd, mw, rr;
      logic [3:0]  be;
      bit          err;
      for (int n = 0; n < 150; n++) begin
         wr   = 2'($urandom_range(1, 2));
         ty   = ($urandom_range(0, 7) != 0) ? 4'($urandom_range(1, 5)) : 4'($urandom_range(0, 15));
         addr = $urandom;
         wd   = $urandom;
         rd   = $urandom;
         model(wr, ty, addr, wd, rd, err, be, mw, rr);
         do_op("rand", wr, ty, addr, wd, rd, $urandom_range(0, 3), $urandom_range(0, 3),
               ($urandom_range(0, 4) == 0), err, be, mw, rr);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_illegal();
      test_gnt_stall();
      test_not_an_op();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
